// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection scheduler and its environment:
// timing/request inputs plus the decoded lamp, countdown and debug outputs.
interface intersection_scheduler_if;
  logic       tick;
  logic       req_b;
  logic       ped_btn;
  logic       night;
  logic [2:0] a_lights;
  logic [2:0] b_lights;
  logic       walk;
  logic       ped_wait;
  logic [3:0] count;
  logic [2:0] phase;

  modport master (
    output tick, req_b, ped_btn, night,
    input  a_lights, b_lights, walk, ped_wait, count, phase
  );

  modport slave (
    input  tick, req_b, ped_btn, night,
    output a_lights, b_lights, walk, ped_wait, count, phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach intersection controller: A main road, B side road and a walk phase,
// all phase timing counted in prescaler ticks, with a night flash override.
module intersection_scheduler #(
  parameter int unsigned T_GREEN_A = 8,
  parameter int unsigned T_GREEN_B = 6,
  parameter int unsigned T_YELLOW  = 3,
  parameter int unsigned T_ALL_RED = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  intersection_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    CLR_AB   = 3'd3,
    B_PHASE  = 3'd4,
    B_YELLOW = 3'd5,
    CLR_BA   = 3'd6,
    FLASH    = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [3:0] timer;
  logic       expire;
  logic       veh_pend, ped_pend, srv_veh, srv_ped, blink;
  logic [2:0] a_lights, b_lights;
  logic       walk;

  function automatic logic [3:0] phase_len(input state_t s);
    case (s)
      INIT_RED, CLR_AB, CLR_BA: return 4'(T_ALL_RED);
      A_GREEN:                  return 4'(T_GREEN_A);
      A_YELLOW, B_YELLOW:       return 4'(T_YELLOW);
      B_PHASE:                  return 4'(T_GREEN_B);
      default:                  return 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT_RED;
    else        state <= next_state;
  end

  // Night wins over any expiry; A green only leaves once its minimum has run out and someone waits.
  always_comb begin
    next_state = state;
    expire     = bus.tick && (timer == 4'd1);
    if (state == FLASH) begin
      if (!bus.night) next_state = INIT_RED;
    end else if (bus.night) begin
      next_state = FLASH;
    end else begin
      case (state)
        INIT_RED: if (expire) next_state = A_GREEN;
        A_GREEN:  if (bus.tick && timer == 4'd0 && (veh_pend || ped_pend)) next_state = A_YELLOW;
        A_YELLOW: if (expire) next_state = CLR_AB;
        CLR_AB:   if (expire) next_state = B_PHASE;
        B_PHASE:  if (expire) next_state = srv_veh ? B_YELLOW : CLR_BA;
        B_YELLOW: if (expire) next_state = CLR_BA;
        CLR_BA:   if (expire) next_state = A_GREEN;
        default:  next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= 4'(T_ALL_RED);
    end else if (next_state != state) begin
      timer <= phase_len(next_state);
    end else if (bus.tick && state != FLASH &&
                 (timer > 4'd1 || (state == A_GREEN && timer != 4'd0))) begin
      timer <= timer - 4'd1;
    end
  end

  // Request latches: B_PHASE entry hands them to srv_*, but a same-clk request re-arms them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      veh_pend <= 1'b0;
      ped_pend <= 1'b0;
      srv_veh  <= 1'b0;
      srv_ped  <= 1'b0;
      blink    <= 1'b0;
    end else begin
      if (state == FLASH || next_state == FLASH) begin
        veh_pend <= 1'b0;
        ped_pend <= 1'b0;
      end else if (next_state == B_PHASE && state != B_PHASE) begin
        srv_veh  <= veh_pend;
        srv_ped  <= ped_pend;
        veh_pend <= bus.req_b;
        ped_pend <= bus.ped_btn;
      end else begin
        veh_pend <= veh_pend | bus.req_b;
        ped_pend <= ped_pend | bus.ped_btn;
      end
      if (state != FLASH) blink <= 1'b0;
      else if (bus.tick)  blink <= ~blink;
    end
  end

  always_comb begin
    a_lights = 3'b001;
    b_lights = 3'b001;
    walk     = 1'b0;
    case (state)
      A_GREEN:  a_lights = 3'b100;
      A_YELLOW: a_lights = 3'b010;
      B_PHASE: begin
        b_lights = srv_veh ? 3'b100 : 3'b001;
        walk     = srv_ped;
      end
      B_YELLOW: b_lights = srv_veh ? 3'b010 : 3'b001;
      FLASH: begin
        a_lights = {1'b0, blink, 1'b0};
        b_lights = {1'b0, blink, 1'b0};
      end
      default: ;
    endcase
  end

  assign bus.a_lights = a_lights;
  assign bus.b_lights = b_lights;
  assign bus.walk     = walk;
  assign bus.ped_wait = ped_pend;
  assign bus.count    = timer;
  assign bus.phase    = state;

endmodule
